// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder
//   Collects a message delivered as a nibble stream and emits the message as
//   SHA-256 padded 512-bit blocks. The padding is the message bits, a single
//   '1' bit, zero fill, and then the 64-bit big-endian bit length. A message
//   is 1..MAX_NIB nibbles long, so each message produces one or two blocks.
//
//   Handshakes: both interfaces use valid/ready. A beat transfers on a rising
//   edge where valid and ready are both high. A producer holds valid and its
//   payload stable until the transfer happens. Ready may depend on state but
//   never on the valid of the same interface.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_nibble / in_last are valid
//   in_ready   padder can accept a nibble (COLLECT state only)
//   in_nibble  message nibble, first nibble is the most significant
//   in_last    marks the final nibble of the message
//   blk_valid  blk_data holds a padded block
//   blk_ready  consumer takes the block
//   blk_data   padded block, bit 511 is the first message bit
//   blk_last   high on the final block of the message
//   msg_bits   bit length of the current message, valid while blk_valid
//   ovf        one-cycle pulse after the MAX_NIB-th nibble arrives without in_last
//   dbg_state  current FSM state, for observation only

module sha256_msg_padder #(
  parameter int MAX_NIB = 128,
  parameter int CNT_W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_nibble,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_last,
  output logic [63:0]  msg_bits,
  output logic         ovf,
  output logic [1:0]   dbg_state
);

  localparam int LEN_W = CNT_W + 2;
  // The largest message that still leaves room for the '1' bit and the
  // 64-bit length in the same block: 4n + 65 <= 512 gives n <= 111.
  localparam int SINGLE_MAX = (4 * MAX_NIB - 65) / 4;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EMIT0   = 2'd1,
    EMIT1   = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [511:0]       blk_buf, buf_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [CNT_W-1:0]   n_cnt;
  logic [LEN_W-1:0]   len_q, len_nxt;
  logic               two_q, two_nxt;
  logic               ovf_q, ovf_nxt;
  logic               nib_xfer;
  logic               blk_xfer;
  logic               full_msg;

  assign in_ready  = (state == COLLECT);
  assign blk_valid = (state == EMIT0) || (state == EMIT1);
  assign nib_xfer  = in_valid && in_ready;
  assign blk_xfer  = blk_valid && blk_ready;
  assign n_cnt     = count + CNT_W'(1);
  assign full_msg  = (len_q == LEN_W'(4 * MAX_NIB));
  assign dbg_state = state;
  assign ovf       = ovf_q;

  assign blk_last = ((state == EMIT0) && !two_q) || (state == EMIT1);
  assign msg_bits = blk_valid ? 64'(len_q) : 64'd0;

  // The first block is the buffer, which already holds the marker and
  // (single-block case) the length. A message of exactly MAX_NIB nibbles
  // puts its '1' bit at the top of the second block.
  always_comb begin
    blk_data = '0;
    if (state == EMIT0) begin
      blk_data = blk_buf;
    end else if (state == EMIT1) begin
      blk_data = {full_msg, 447'd0, 64'(len_q)};
    end
  end

  always_comb begin
    state_nxt = state;
    buf_nxt   = blk_buf;
    count_nxt = count;
    len_nxt   = len_q;
    two_nxt   = two_q;
    ovf_nxt   = 1'b0;
    case (state)
      COLLECT: begin
        if (nib_xfer) begin
          buf_nxt[511 - 4 * int'(count) -: 4] = in_nibble;
          count_nxt = n_cnt;
          if (in_last || (count == CNT_W'(MAX_NIB - 1))) begin
            state_nxt = EMIT0;
            len_nxt   = {n_cnt, 2'b00};
            two_nxt   = (int'(n_cnt) > SINGLE_MAX);
            ovf_nxt   = !in_last;
            // The padding is placed in the buffer now so that the first
            // block can be shown directly from the register.
            if (int'(n_cnt) < MAX_NIB) begin
              buf_nxt[511 - 4 * int'(n_cnt) -: 4] = 4'h8;
            end
            if (int'(n_cnt) <= SINGLE_MAX) begin
              buf_nxt[63:0] = 64'({n_cnt, 2'b00});
            end
          end
        end
      end
      EMIT0: begin
        if (blk_xfer) begin
          if (two_q) begin
            state_nxt = EMIT1;
          end else begin
            state_nxt = COLLECT;
            buf_nxt   = '0;
            count_nxt = '0;
          end
        end
      end
      EMIT1: begin
        if (blk_xfer) begin
          state_nxt = COLLECT;
          buf_nxt   = '0;
          count_nxt = '0;
        end
      end
      default: begin
        state_nxt = COLLECT;
        buf_nxt   = '0;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= COLLECT;
      blk_buf <= '0;
      count   <= '0;
      len_q   <= '0;
      two_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      blk_buf <= buf_nxt;
      count   <= count_nxt;
      len_q   <= len_nxt;
      two_q   <= two_nxt;
      ovf_q   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder
//   Directed bench for sha256_msg_padder. The stimulus is a linear sequence
//   of steps, and the expected blocks are hand-written constants. Inputs are
//   driven and outputs sampled on the falling clock edge.

module tb_sha256_msg_padder;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_nibble;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;
  logic [63:0]  msg_bits;
  logic         ovf;
  logic [1:0]   dbg_state;

  int checks;
  int failures;
  int ovf_cnt;
  logic [3:0] msg [0:127];
  logic [511:0] held;

  sha256_msg_padder #(.MAX_NIB(128), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_nibble (in_nibble),
    .in_last   (in_last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last),
    .msg_bits  (msg_bits),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ovf === 1'b1) ovf_cnt++;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [3:0] v, input int n);
    for (int k = 0; k < n; k++) msg[k] = v;
  endtask

  // Drives msg[0..n-1] and returns on the falling edge after the last transfer.
  task automatic send(input int n, input bit mark_last);
    for (int k = 0; k < n; k++) begin
      int guard;
      in_valid  = 1'b1;
      in_nibble = msg[k];
      in_last   = mark_last && (k == n - 1);
      guard = 0;
      while (in_ready !== 1'b1 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        chk("in_ready_timeout", 512'(in_ready), 512'd1);
        k = n;
      end else begin
        @(negedge clk);
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_nibble = 4'h0;
  endtask

  // Expects a block to be offered right now, checks it, then takes it.
  task automatic take(input string tag, input logic [511:0] exp_data,
                      input bit exp_last, input logic [63:0] exp_bits);
    chk({tag, "_valid"}, 512'(blk_valid), 512'd1);
    chk({tag, "_data"}, blk_data, exp_data);
    chk({tag, "_last"}, 512'(blk_last), 512'(exp_last));
    chk({tag, "_bits"}, 512'(msg_bits), 512'(exp_bits));
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    ovf_cnt   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_nibble = 4'h0;
    in_last   = 1'b0;
    blk_ready = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_in_ready", 512'(in_ready), 512'd1);
    chk("rst_blk_valid", 512'(blk_valid), 512'd0);
    chk("rst_blk_data", blk_data, 512'd0);
    chk("rst_blk_last", 512'(blk_last), 512'd0);
    chk("rst_msg_bits", 512'(msg_bits), 512'd0);
    chk("rst_ovf", 512'(ovf), 512'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: "abc"
    msg[0] = 4'h6; msg[1] = 4'h1; msg[2] = 4'h6;
    msg[3] = 4'h2; msg[4] = 4'h6; msg[5] = 4'h3;
    send(6, 1'b1);
    chk("abc_in_ready_low", 512'(in_ready), 512'd0);
    take("abc", {32'h61626380, 416'd0, 64'h18}, 1'b1, 64'd24);
    chk("abc_in_ready_back", 512'(in_ready), 512'd1);
    chk("abc_valid_drop", 512'(blk_valid), 512'd0);

    // 2: 111 nibbles, the longest single-block message
    fill(4'hA, 111);
    send(111, 1'b1);
    take("n111", {{111{4'hA}}, 4'h8, 64'h1BC}, 1'b1, 64'h1BC);

    // 3: 112 nibbles, the shortest two-block message
    fill(4'h5, 112);
    send(112, 1'b1);
    take("n112_b0", {{112{4'h5}}, 4'h8, 60'd0}, 1'b0, 64'h1C0);
    take("n112_b1", {448'd0, 64'h1C0}, 1'b1, 64'h1C0);
    chk("n112_done", 512'(blk_valid), 512'd0);

    // 4a: 128 nibbles, in_last on the final one
    fill(4'hC, 128);
    ovf_cnt = 0;
    send(128, 1'b1);
    take("n128l_b0", {128{4'hC}}, 1'b0, 64'h200);
    take("n128l_b1", {4'h8, 444'd0, 64'h200}, 1'b1, 64'h200);
    chk("n128l_ovf", 512'(ovf_cnt), 512'd0);

    // 4b: 128 nibbles, no in_last, truncated with an ovf pulse
    ovf_cnt = 0;
    send(128, 1'b0);
    take("n128t_b0", {128{4'hC}}, 1'b0, 64'h200);
    take("n128t_b1", {4'h8, 444'd0, 64'h200}, 1'b1, 64'h200);
    repeat (2) @(negedge clk);
    chk("n128t_ovf", 512'(ovf_cnt), 512'd1);

    // 5: backpressure on "abc", with a competing nibble offered meanwhile
    msg[0] = 4'h6; msg[1] = 4'h1; msg[2] = 4'h6;
    msg[3] = 4'h2; msg[4] = 4'h6; msg[5] = 4'h3;
    send(6, 1'b1);
    held = blk_data;
    in_valid  = 1'b1;
    in_nibble = 4'hF;
    in_last   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_stable", blk_data, held);
      chk("bp_in_ready", 512'(in_ready), 512'd0);
      chk("bp_valid_hold", 512'(blk_valid), 512'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    take("bp", {32'h61626380, 416'd0, 64'h18}, 1'b1, 64'd24);
    chk("bp_in_ready_after", 512'(in_ready), 512'd1);
    msg[0] = 4'h4; msg[1] = 4'h1;
    send(2, 1'b1);
    take("bp_next", {12'h418, 436'd0, 64'h8}, 1'b1, 64'd8);

    // 6: reset while the second block is pending
    fill(4'h3, 120);
    send(120, 1'b1);
    take("n120_b0", {{120{4'h3}}, 4'h8, 28'd0}, 1'b0, 64'h1E0);
    chk("n120_b1_pending", 512'(blk_valid), 512'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 512'(blk_valid), 512'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rel_in_ready", 512'(in_ready), 512'd1);
    chk("rst_rel_no_block", 512'(blk_valid), 512'd0);
    msg[0] = 4'h6; msg[1] = 4'h1; msg[2] = 4'h6;
    msg[3] = 4'h2; msg[4] = 4'h6; msg[5] = 4'h3;
    send(6, 1'b1);
    take("post_rst_abc", {32'h61626380, 416'd0, 64'h18}, 1'b1, 64'd24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
